cross_bar_router_1xn: RTL and testbench
=======================================

CROSS_BAR_ROUTER_1XN -- requirements
Module: cross_bar_router_1xn

Interface
REQ-001 SHALL have parameter SSEL_WIDTH, default 2, width of the destination select field.
REQ-002 SHALL have parameter CHANNEL_NO, default 2**SSEL_WIDTH, number of output channels.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, stream data width; SSEL_WIDTH <= DATA_WIDTH.
REQ-004 aclk  input  1  single clock; all logic on rising edge.
REQ-005 areset  input  1  reset, synchronous and active-high.
REQ-006 s_axis_tdata  input  DATA_WIDTH  ingress data; first beat carries destination in bits [DATA_WIDTH-1 -: SSEL_WIDTH].
REQ-007 s_axis_tvalid  input  1  ingress valid.
REQ-008 s_axis_tlast  input  1  ingress end-of-packet.
REQ-009 s_axis_tready  output  1  ingress ready.
REQ-010 m_axis_tdata  output  DATA_WIDTH x CHANNEL_NO (unpacked array)  egress data per channel.
REQ-011 m_axis_tvalid  output  1 x CHANNEL_NO  egress valid per channel.
REQ-012 m_axis_tlast  output  1 x CHANNEL_NO  egress end-of-packet per channel.
REQ-013 m_axis_tready  input  1 x CHANNEL_NO  egress ready per channel.

Function
REQ-014 SHALL route each ingress packet unmodified (header beat included) to exactly one output channel, chosen by the destination field of its first beat.
REQ-015 SHALL implement states IDLE (awaiting first beat) and ACTIVE (route locked).
REQ-016 IDLE: ingress handshake with tlast=0 -> latch destination into route register, go ACTIVE; with tlast=1 (single-beat packet) -> stay IDLE.
REQ-017 ACTIVE: beats use the latched route regardless of their data; ingress handshake with tlast=1 -> IDLE.
REQ-018 SHALL buffer egress through a 2-entry skid buffer (main + skid) holding data, last and destination per entry.
REQ-019 Latency: ingress handshake at cycle N -> beat on m_axis_* at cycle N+1 when main entry was empty or draining.
REQ-020 s_axis_tready SHALL equal NOT skid_valid (registered, no combinational path from m_axis_tready).
REQ-021 m_axis_tvalid[i] SHALL be main_valid AND main_dest==i; all other channels' tvalid SHALL be 0.
REQ-022 m_axis_tdata[i]/m_axis_tlast[i] SHALL present main entry for the selected channel; tlast 0 on unselected channels.
REQ-023 m_axis_tready of unselected channels SHALL be ignored.
REQ-024 Simultaneous ingress accept and egress drain SHALL sustain one beat per cycle with no bubble.
REQ-025 On egress drain with skid full, skid entry SHALL move to main the same edge; beat order SHALL be preserved.
REQ-026 Consecutive packets to different channels SHALL be emitted back-to-back; a stalled channel SHALL block all later packets (no reordering).

Reset
REQ-027 areset SHALL clear state to IDLE, route register to 0, main_valid and skid_valid to 0 on the next rising edge.
REQ-028 After reset all m_axis_tvalid SHALL be 0 and s_axis_tready SHALL be 1.
REQ-029 Reset mid-packet SHALL discard buffered beats; the next ingress beat SHALL be treated as a first (header) beat.

Configuration
REQ-030 Macro CROSS_BAR_ROUTER_PKT_CNT_EN, when defined, SHALL add output port pkt_count (16 bits x CHANNEL_NO).
REQ-031 With macro: pkt_count[i] SHALL increment on each egress handshake with m_axis_tlast[i]=1, wrap 0xFFFF -> 0x0000, reset to 0.
REQ-032 Without macro: port and counters SHALL be absent; routing behaviour identical.

Verification
REQ-033 4-beat packet, header 0x8000_0000 (dest 2), all tready=1 -> beats appear only on channel 2 at cycles N+1..N+4, tlast on 4th.
REQ-034 Single-beat packet header 0xC000_00AA with tlast=1 -> one beat on channel 3 with tlast=1; next beat header 0x0000_0001 -> channel 0.
REQ-035 m_axis_tready[1]=0 during a packet to channel 1 -> s_axis_tready falls after 2 beats accepted; release -> all beats delivered in order, none lost.
REQ-036 areset asserted after 2 of 5 beats -> all tvalid 0, s_axis_tready 1 next cycle; following beat 0x4000_0000 routed to channel 1.
REQ-037 With CROSS_BAR_ROUTER_PKT_CNT_EN: 3 packets to channel 0 -> pkt_count[0]=3, others 0; preload 0xFFFF then one packet -> 0x0000.

Source files
------------

// File: rtl/cross_bar_router_1xn.sv
// 1-to-N AXI-Stream packet router: the first beat's top SSEL_WIDTH bits select the output channel.
// Optional per-channel packet counters are compiled in with `define CROSS_BAR_ROUTER_PKT_CNT_EN.
module cross_bar_router_1xn #(
  parameter int unsigned SSEL_WIDTH = 2,
  parameter int unsigned CHANNEL_NO = 2**SSEL_WIDTH,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata [CHANNEL_NO],
  output logic [CHANNEL_NO-1:0] m_axis_tvalid,
  output logic [CHANNEL_NO-1:0] m_axis_tlast,
  input  logic [CHANNEL_NO-1:0] m_axis_tready
`ifdef CROSS_BAR_ROUTER_PKT_CNT_EN
  ,
  output logic [15:0]           pkt_count [CHANNEL_NO]
`endif
);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StActive = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [SSEL_WIDTH-1:0] route_q, route_d;

  logic                  main_valid_q, main_valid_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic                  main_last_q, main_last_d;
  logic [SSEL_WIDTH-1:0] main_dest_q, main_dest_d;

  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  skid_last_q, skid_last_d;
  logic [SSEL_WIDTH-1:0] skid_dest_q, skid_dest_d;

  logic [SSEL_WIDTH-1:0] hdr_dest;
  logic [SSEL_WIDTH-1:0] in_dest;
  logic                  in_hs;
  logic                  drain;

  assign s_axis_tready = ~skid_valid_q;
  assign hdr_dest      = s_axis_tdata[DATA_WIDTH-1 -: SSEL_WIDTH];
  assign in_dest       = (state_q == StIdle) ? hdr_dest : route_q;
  assign in_hs         = s_axis_tvalid & ~skid_valid_q;
  // Only the selected channel has tvalid set, so unselected tready bits drop out here.
  assign drain         = |(m_axis_tvalid & m_axis_tready);

  always_comb begin
    for (int i = 0; i < CHANNEL_NO; i++) begin
      m_axis_tvalid[i] = main_valid_q && (main_dest_q == SSEL_WIDTH'(i));
      m_axis_tlast[i]  = m_axis_tvalid[i] & main_last_q;
      m_axis_tdata[i]  = m_axis_tvalid[i] ? main_data_q : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    if (in_hs) begin
      if (state_q == StIdle) begin
        if (!s_axis_tlast) begin
          state_d = StActive;
          route_d = hdr_dest;
        end
      end else if (s_axis_tlast) begin
        state_d = StIdle;
      end
    end
  end

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_last_d  = main_last_q;
    main_dest_d  = main_dest_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    skid_dest_d  = skid_dest_q;
    if (drain || !main_valid_q) begin
      // Main is free this edge: refill from skid first to keep beat order.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_last_d  = skid_last_q;
        main_dest_d  = skid_dest_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = in_hs;
        main_data_d  = s_axis_tdata;
        main_last_d  = s_axis_tlast;
        main_dest_d  = in_dest;
      end
    end else if (in_hs) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_axis_tdata;
      skid_last_d  = s_axis_tlast;
      skid_dest_d  = in_dest;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= StIdle;
      route_q      <= '0;
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_last_q  <= 1'b0;
      main_dest_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      skid_dest_q  <= '0;
    end else begin
      state_q      <= state_d;
      route_q      <= route_d;
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_last_q  <= main_last_d;
      main_dest_q  <= main_dest_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      skid_dest_q  <= skid_dest_d;
    end
  end

`ifdef CROSS_BAR_ROUTER_PKT_CNT_EN
  logic [15:0] pkt_count_q [CHANNEL_NO];

  always_ff @(posedge aclk) begin
    for (int i = 0; i < CHANNEL_NO; i++) begin
      if (areset) begin
        pkt_count_q[i] <= '0;
      end else if (m_axis_tvalid[i] && m_axis_tready[i] && m_axis_tlast[i]) begin
        pkt_count_q[i] <= pkt_count_q[i] + 16'd1;
      end
    end
  end

  assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_cross_bar_router_1xn.sv
// Randomized and directed bench for cross_bar_router_1xn against a queue-based packet model.
module tb_cross_bar_router_1xn;
  localparam int SW = 2;
  localparam int CH = 4;
  localparam int DW = 32;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata [CH];
  logic [CH-1:0] m_tvalid;
  logic [CH-1:0] m_tlast;
  logic [CH-1:0] m_tready = '1;
`ifdef CROSS_BAR_ROUTER_PKT_CNT_EN
  logic [15:0]   pkt_count [CH];
`endif

  cross_bar_router_1xn #(.SSEL_WIDTH(SW), .CHANNEL_NO(CH), .DATA_WIDTH(DW)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready)
`ifdef CROSS_BAR_ROUTER_PKT_CNT_EN
    ,
    .pkt_count     (pkt_count)
`endif
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    int            dest;
  } beat_t;

  int    checks = 0;
  int    failures = 0;
  beat_t q[$];
  bit    in_pkt = 0;
  int    route = 0;
  int    exp_cnt [CH];
  bit    ing_hs = 0;
  bit    rnd_rdy = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an ordered queue of accepted beats; the head is always on the egress port.
  always @(negedge aclk) begin : model_p
    logic [CH-1:0] ev;
    logic [CH-1:0] el;
    bit            drn;
    beat_t         b;
    ev = '0;
    el = '0;
    if (q.size() > 0) begin
      ev[q[0].dest] = 1'b1;
      if (q[0].l) el = ev;
    end
    chk("s_tready", 64'(s_tready), 64'(q.size() < 2));
    chk("m_tvalid", 64'(m_tvalid), 64'(ev));
    chk("m_tlast", 64'(m_tlast), 64'(el));
    if (q.size() > 0) chk("m_tdata", 64'(m_tdata[q[0].dest]), 64'(q[0].d));
    if (areset) begin
      q.delete();
      in_pkt = 0;
      route = 0;
      ing_hs = 0;
      for (int i = 0; i < CH; i++) exp_cnt[i] = 0;
    end else begin
      drn = (q.size() > 0) && m_tready[q[0].dest];
      ing_hs = s_tvalid && (q.size() < 2);
      if (drn) begin
        if (q[0].l) exp_cnt[q[0].dest] = (exp_cnt[q[0].dest] + 1) % 65536;
        void'(q.pop_front());
      end
      if (ing_hs) begin
        b.d = s_tdata;
        b.l = s_tlast;
        if (!in_pkt) begin
          b.dest = int'(s_tdata[DW-1 -: SW]);
          if (!s_tlast) begin
            in_pkt = 1;
            route = b.dest;
          end
        end else begin
          b.dest = route;
          if (s_tlast) in_pkt = 0;
        end
        q.push_back(b);
      end
    end
  end

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      if (rnd_rdy) m_tready = CH'($urandom);
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the beat was accepted.
  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    int n;
    n = 0;
    s_tdata = d;
    s_tlast = l;
    s_tvalid = 1'b1;
    do begin
      @(posedge aclk);
      n++;
    end while (!ing_hs && n < 300);
    #1;
    s_tvalid = 1'b0;
    if (!ing_hs) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got no accept expected accept within 300 cycles");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [CH-1:0] v, input logic [CH-1:0] l,
                         input int ch, input logic [DW-1:0] d);
    chk({name, "_valid"}, 64'(m_tvalid), 64'(v));
    chk({name, "_last"}, 64'(m_tlast), 64'(l));
    chk({name, "_data"}, 64'(m_tdata[ch]), 64'(d));
  endtask

  initial begin
    int len;
    int dst;
    logic [DW-1:0] d;
    for (int i = 0; i < CH; i++) exp_cnt[i] = 0;
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;
    chk("rst_valid", 64'(m_tvalid), 64'(0));
    chk("rst_ready", 64'(s_tready), 64'(1));

    // 4-beat packet to channel 2; later beats carry dest bits that must be ignored
    send_beat(32'h8000_0000, 1'b0);
    chk_out("p4_b0", 4'b0100, 4'b0000, 2, 32'h8000_0000);
    send_beat(32'h0000_0011, 1'b0);
    chk_out("p4_b1", 4'b0100, 4'b0000, 2, 32'h0000_0011);
    send_beat(32'h4000_0022, 1'b0);
    chk_out("p4_b2", 4'b0100, 4'b0000, 2, 32'h4000_0022);
    send_beat(32'hC000_0033, 1'b1);
    chk_out("p4_b3", 4'b0100, 4'b0100, 2, 32'hC000_0033);

    // Single-beat packets
    send_beat(32'hC000_00AA, 1'b1);
    chk_out("single3", 4'b1000, 4'b1000, 3, 32'hC000_00AA);
    send_beat(32'h0000_0001, 1'b1);
    chk_out("single0", 4'b0001, 4'b0001, 0, 32'h0000_0001);
    idle(2);

    // Backpressure on channel 1
    m_tready = 4'b1101;
    send_beat(32'h4000_0000, 1'b0);
    chk_out("bp_b0", 4'b0010, 4'b0000, 1, 32'h4000_0000);
    send_beat(32'h0000_0005, 1'b0);
    chk("bp_ready_low", 64'(s_tready), 64'(0));
    idle(3);
    chk("bp_ready_held", 64'(s_tready), 64'(0));
    chk_out("bp_hold", 4'b0010, 4'b0000, 1, 32'h4000_0000);
    m_tready = 4'b1111;
    send_beat(32'h0000_0006, 1'b0);
    send_beat(32'h0000_0007, 1'b1);
    idle(4);

    // Reset mid-packet
    send_beat(32'hC000_0000, 1'b0);
    send_beat(32'h0000_0001, 1'b0);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    chk("mrst_valid", 64'(m_tvalid), 64'(0));
    chk("mrst_ready", 64'(s_tready), 64'(1));
    send_beat(32'h4000_0000, 1'b1);
    chk_out("mrst_hdr", 4'b0010, 4'b0010, 1, 32'h4000_0000);
    idle(2);

    // Randomized traffic with random per-channel backpressure
    rnd_rdy = 1;
    for (int p = 0; p < 80; p++) begin
      len = int'($urandom_range(1, 5));
      dst = int'($urandom_range(0, CH - 1));
      for (int b = 0; b < len; b++) begin
        d = $urandom;
        if (b == 0) d[DW-1 -: SW] = SW'(dst);
        send_beat(d, b == len - 1);
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
    end
    rnd_rdy = 0;
    @(posedge aclk);
    #2;
    m_tready = '1;
    for (int n = 0; n < 20 && q.size() > 0; n++) @(posedge aclk);
    #1;
    chk("drain_empty", 64'(q.size()), 64'(0));
`ifdef CROSS_BAR_ROUTER_PKT_CNT_EN
    @(negedge aclk);
    for (int i = 0; i < CH; i++) chk("pkt_count", 64'(pkt_count[i]), 64'(exp_cnt[i]));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
